// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use unsigned shift-add on operand magnitudes, DIV/DIVU use
// restoring division; a final FIX cycle applies sign correction and
// writes HI/LO. MTHI/MTLO write HI/LO directly while the unit is idle.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             MtHi,
    input  logic             MtLo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negate of a WIDTH-bit value when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        cond_neg_w = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value when neg is set.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        cond_neg_2w = neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // product / quotient negative
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    // Operand decode at Start: signed ops work on magnitudes.
    logic               signed_op_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;

    assign signed_op_s = ~Op[0];
    assign a_neg_s     = signed_op_s & OperandA[WIDTH-1];
    assign b_neg_s     = signed_op_s & OperandB[WIDTH-1];
    assign a_mag_s     = cond_neg_w(OperandA, a_neg_s);
    assign b_mag_s     = cond_neg_w(OperandB, b_neg_s);

    // One shift-add multiply iteration: add multiplicand if LSB set, shift right.
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_step_s;

    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};

    // One restoring divide iteration: shift next dividend bit in, trial-subtract.
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_step_s;

    assign div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign div_step_s  = div_trial_s[WIDTH]
                       ? {acc_q[2*WIDTH-2:0], 1'b0}
                       : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results. With a zero divisor every trial subtraction
    // leaves the shifted dividend intact, so the remainder ends as the
    // dividend magnitude and its sign correction reproduces OperandA.
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    assign prod_fix_s = cond_neg_2w(acc_q, neg_res_q);
    assign quo_fix_s  = cond_neg_w(acc_q[WIDTH-1:0], neg_res_q);
    assign rem_fix_s  = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    is_div_d  = Op[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    div0_d    = Op[1] & (OperandB == ZERO_W);
                    if (Op[1]) begin
                        acc_d  = {ZERO_W, a_mag_s};
                        opnd_d = b_mag_s;
                    end else begin
                        acc_d  = {ZERO_W, b_mag_s};
                        opnd_d = a_mag_s;
                    end
                    cnt_d   = CNT_MAX;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    if (MtHi) begin
                        hi_d = OperandA;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (MtLo) begin
                        lo_d = OperandA;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_RUN: begin
                if (is_div_q) begin
                    acc_d = div_step_s;
                end else begin
                    acc_d = mul_step_s;
                end
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = ONES_W;
                    end else begin
                        lo_d = quo_fix_s;
                    end
                    hi_d      = rem_fix_s;
                    divzero_d = div0_q;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            acc_q     <= {(2*WIDTH){1'b0}};
            opnd_q    <= ZERO_W;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule
